// File: rtl/pcs_pkg.sv
// pcs_pkg: shared PCS block widths and 64b/66b sync header encodings.
// Imported by the loopback lane and top.
package pcs_pkg;

    localparam int HEAD_W  = 2;
    localparam int DATA_W  = 64;
    localparam int BLOCK_W = HEAD_W + DATA_W;

    typedef enum logic [HEAD_W-1:0] {
        SYNC_BAD  = 2'b00,
        SYNC_DATA = 2'b01,
        SYNC_CTRL = 2'b10
    } sync_hdr_e;

endpackage

// File: rtl/pcs_lane_loopback_lane.sv
// pcs_lane_loopback_lane: one emulated serdes lane (skew buffer, bit window, slip).
// Define PCS_LB_ERR_INJ_EN to add the err_inj sync-header corruption input.
module pcs_lane_loopback_lane
    import pcs_pkg::*;
#(
    parameter int SKEW_DEPTH = 16,
    parameter int SKEW_W     = $clog2(SKEW_DEPTH),
    parameter int OFF_W      = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_v,
    input  logic [BLOCK_W-1:0] tx_block,
    input  logic [SKEW_W-1:0]  skew_cfg,
    input  logic [OFF_W-1:0]   off_cfg,
    input  logic               slip,
`ifdef PCS_LB_ERR_INJ_EN
    input  logic               err_inj,
`endif
    output logic               serdes_v,
    output logic [HEAD_W-1:0]  serdes_head,
    output logic [DATA_W-1:0]  serdes_data,
    output logic [OFF_W-1:0]   off
);

    localparam int FILL_W = $clog2(SKEW_DEPTH + 1);
    localparam logic [SKEW_W-1:0] SKEW_MAX  = SKEW_W'(SKEW_DEPTH - 2);
    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(BLOCK_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SKEW_DEPTH);

    // Pointers wrap by width, so SKEW_DEPTH is a power of two.
    logic [BLOCK_W-1:0] mem_q [SKEW_DEPTH];
    logic [SKEW_W-1:0]  wr_ptr_q;
    logic [SKEW_W-1:0]  skew_q;
    logic [SKEW_W-1:0]  ptr_new;
    logic [SKEW_W-1:0]  ptr_old;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_nxt;
    logic [OFF_W-1:0]   off_q;
    logic [BLOCK_W-1:0] blk_new;
    logic [BLOCK_W-1:0] blk_old;
    logic [BLOCK_W-1:0] word;
    logic [HEAD_W-1:0]  head;
    logic               emit;

`ifdef PCS_LB_ERR_INJ_EN
    logic err_q;
`endif

    always_comb begin
        fill_nxt = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        ptr_new  = wr_ptr_q - skew_q;
        ptr_old  = ptr_new - 1'b1;
        // At zero skew the newer half of the window is the block landing now.
        blk_new  = (skew_q == '0) ? tx_block : mem_q[ptr_new];
        blk_old  = mem_q[ptr_old];
        word     = BLOCK_W'({blk_new, blk_old} >> off_q);
        emit     = tx_v && (fill_nxt >= FILL_W'(skew_q) + FILL_W'(2));
        head     = word[HEAD_W-1:0];
`ifdef PCS_LB_ERR_INJ_EN
        if (err_q) begin
            head = SYNC_BAD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset && tx_v) begin
            mem_q[wr_ptr_q] <= tx_block;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            serdes_v    <= 1'b0;
            serdes_head <= '0;
            serdes_data <= '0;
            skew_q      <= (skew_cfg > SKEW_MAX) ? SKEW_MAX : skew_cfg;
            off_q       <= (off_cfg > OFF_LAST) ? '0 : off_cfg;
        end else begin
            serdes_v <= emit;
            if (tx_v) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                fill_q   <= fill_nxt;
            end
            if (emit) begin
                serdes_head <= head;
                serdes_data <= word[BLOCK_W-1:HEAD_W];
            end
            if (slip) begin
                off_q <= (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
            end
        end
    end

`ifdef PCS_LB_ERR_INJ_EN
    // An armed error is consumed by the next emitted word; a pulse re-arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (err_q && !emit) || err_inj;
        end
    end
`endif

    assign off = off_q;

endmodule

// File: rtl/pcs_lane_loopback.sv
// pcs_lane_loopback: multi-lane PMA/serdes emulator looping pcs_tx back to pcs_rx.
// Define PCS_LB_ERR_INJ_EN to add err_inj_i for invalid sync header injection.
module pcs_lane_loopback
    import pcs_pkg::*;
#(
    parameter int LANE_N     = 4,
    parameter int SKEW_DEPTH = 16,
    parameter int SKEW_W     = $clog2(SKEW_DEPTH),
    parameter int OFF_W      = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANE_N-1:0]         tx_v_i,
    input  logic [LANE_N*BLOCK_W-1:0] tx_block_i,
    input  logic [LANE_N*SKEW_W-1:0]  skew_cfg_i,
    input  logic [LANE_N*OFF_W-1:0]   off_cfg_i,
    input  logic [LANE_N-1:0]         gearbox_slip_i,
`ifdef PCS_LB_ERR_INJ_EN
    input  logic [LANE_N-1:0]         err_inj_i,
`endif
    output logic [LANE_N-1:0]         serdes_v_o,
    output logic [LANE_N*HEAD_W-1:0]  serdes_head_o,
    output logic [LANE_N*DATA_W-1:0]  serdes_data_o,
    output logic [LANE_N*OFF_W-1:0]   off_o
);

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        pcs_lane_loopback_lane #(
            .SKEW_DEPTH (SKEW_DEPTH),
            .SKEW_W     (SKEW_W),
            .OFF_W      (OFF_W)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .tx_v        (tx_v_i[l]),
            .tx_block    (tx_block_i[l*BLOCK_W +: BLOCK_W]),
            .skew_cfg    (skew_cfg_i[l*SKEW_W +: SKEW_W]),
            .off_cfg     (off_cfg_i[l*OFF_W +: OFF_W]),
            .slip        (gearbox_slip_i[l]),
`ifdef PCS_LB_ERR_INJ_EN
            .err_inj     (err_inj_i[l]),
`endif
            .serdes_v    (serdes_v_o[l]),
            .serdes_head (serdes_head_o[l*HEAD_W +: HEAD_W]),
            .serdes_data (serdes_data_o[l*DATA_W +: DATA_W]),
            .off         (off_o[l*OFF_W +: OFF_W])
        );
    end

endmodule

// File: tb/tb_pcs_lane_loopback.sv
// tb_pcs_lane_loopback: randomized bench for pcs_lane_loopback against a block-history model.
// Define PCS_LB_ERR_INJ_EN to also cover sync header error injection.
module tb_pcs_lane_loopback;
    import pcs_pkg::*;

    localparam int LN   = 4;
    localparam int SW   = 4;
    localparam int OW   = 7;
    localparam int HMAX = 8192;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [LN-1:0]          tx_v_i = '0;
    logic [LN*BLOCK_W-1:0]  tx_block_i = '0;
    logic [LN*SW-1:0]       skew_cfg_i = '0;
    logic [LN*OW-1:0]       off_cfg_i = '0;
    logic [LN-1:0]          gearbox_slip_i = '0;
`ifdef PCS_LB_ERR_INJ_EN
    logic [LN-1:0]          err_inj_i = '0;
`endif
    logic [LN-1:0]          serdes_v_o;
    logic [LN*HEAD_W-1:0]   serdes_head_o;
    logic [LN*DATA_W-1:0]   serdes_data_o;
    logic [LN*OW-1:0]       off_o;

    always #5 clk = ~clk;

    pcs_lane_loopback #(
        .LANE_N     (LN),
        .SKEW_DEPTH (16),
        .SKEW_W     (SW),
        .OFF_W      (OW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_v_i         (tx_v_i),
        .tx_block_i     (tx_block_i),
        .skew_cfg_i     (skew_cfg_i),
        .off_cfg_i      (off_cfg_i),
        .gearbox_slip_i (gearbox_slip_i),
`ifdef PCS_LB_ERR_INJ_EN
        .err_inj_i      (err_inj_i),
`endif
        .serdes_v_o     (serdes_v_o),
        .serdes_head_o  (serdes_head_o),
        .serdes_data_o  (serdes_data_o),
        .off_o          (off_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: every block accepted since reset, indexed by arrival order.
    logic [BLOCK_W-1:0] hist [LN][HMAX];
    int                 cnt    [LN];
    int                 skew_m [LN];
    int                 off_m  [LN];
    bit                 arm    [LN];
    logic               exp_v  [LN];
    logic [HEAD_W-1:0]  exp_h  [LN];
    logic [DATA_W-1:0]  exp_d  [LN];

    function automatic logic [BLOCK_W-1:0] rand_block();
        logic [DATA_W-1:0] d;
        logic [HEAD_W-1:0] h;
        d = {$urandom, $urandom};
        h = ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTRL;
        return {d, h};
    endfunction

    task automatic do_reset(input logic [LN*SW-1:0] sk, input logic [LN*OW-1:0] of);
        int s;
        int o;
        reset = 1'b1;
        skew_cfg_i = sk;
        off_cfg_i = of;
        tx_v_i = LN'($urandom);
        gearbox_slip_i = LN'($urandom);
        for (int l = 0; l < LN; l++) tx_block_i[l*BLOCK_W +: BLOCK_W] = rand_block();
        @(negedge clk);
        for (int l = 0; l < LN; l++) begin
            s = int'(sk[l*SW +: SW]);
            o = int'(of[l*OW +: OW]);
            cnt[l] = 0;
            skew_m[l] = (s > 14) ? 14 : s;
            off_m[l] = (o >= BLOCK_W) ? 0 : o;
            arm[l] = 1'b0;
            exp_v[l] = 1'b0;
            exp_h[l] = '0;
            exp_d[l] = '0;
        end
        reset = 1'b0;
        tx_v_i = '0;
        gearbox_slip_i = '0;
    endtask

    // Drives one cycle of stimulus and advances the model to what the DUT should show after it.
    task automatic cycle(input logic [LN-1:0] v, input logic [LN-1:0] slip, input logic [LN-1:0] inj);
        logic [BLOCK_W-1:0]   blk;
        logic [BLOCK_W-1:0]   w;
        logic [2*BLOCK_W-1:0] win;
        int n;
        for (int l = 0; l < LN; l++) begin
            blk = rand_block();
            tx_block_i[l*BLOCK_W +: BLOCK_W] = blk;
            exp_v[l] = 1'b0;
            if (v[l]) begin
                hist[l][cnt[l]] = blk;
                cnt[l]++;
                n = cnt[l];
                if (n >= skew_m[l] + 2) begin
                    win = {hist[l][n-1-skew_m[l]], hist[l][n-2-skew_m[l]]};
                    w = BLOCK_W'(win >> off_m[l]);
                    exp_v[l] = 1'b1;
                    exp_h[l] = w[HEAD_W-1:0];
                    exp_d[l] = w[BLOCK_W-1:HEAD_W];
                    if (arm[l]) begin
                        exp_h[l] = '0;
                        arm[l] = 1'b0;
                    end
                end
            end
            if (inj[l]) arm[l] = 1'b1;
            if (slip[l]) off_m[l] = (off_m[l] == BLOCK_W - 1) ? 0 : off_m[l] + 1;
        end
        tx_v_i = v;
        gearbox_slip_i = slip;
`ifdef PCS_LB_ERR_INJ_EN
        err_inj_i = inj;
`endif
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset('0, '0);
        for (int l = 0; l < LN; l++) begin
            n_vec++;
            if (serdes_v_o[l] !== 1'b0 || serdes_head_o[l*HEAD_W +: HEAD_W] !== '0 ||
                serdes_data_o[l*DATA_W +: DATA_W] !== '0 || off_o[l*OW +: OW] !== '0) begin
                n_bad++;
                $display("FAIL reset lane %0d: got v=%b h=%b d=%h off=%0d, want all zero", l,
                         serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                         serdes_data_o[l*DATA_W +: DATA_W], off_o[l*OW +: OW]);
            end
        end
    endtask

    task automatic test_passthrough();
        do_reset('0, '0);
        for (int i = 0; i < 40; i++) begin
            cycle('1, '0, '0);
            for (int l = 0; l < LN; l++) begin
                n_vec++;
                if (serdes_v_o[l] !== exp_v[l] || serdes_head_o[l*HEAD_W +: HEAD_W] !== exp_h[l] ||
                    serdes_data_o[l*DATA_W +: DATA_W] !== exp_d[l]) begin
                    n_bad++;
                    $display("FAIL passthru cyc %0d lane %0d: got v=%b h=%b d=%h want v=%b h=%b d=%h",
                             i, l, serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                             serdes_data_o[l*DATA_W +: DATA_W], exp_v[l], exp_h[l], exp_d[l]);
                end
            end
        end
    endtask

    task automatic test_skew();
        int first3;
        first3 = -1;
        do_reset({4'd15, 4'd7, 4'd3, 4'd0}, '0);
        for (int i = 0; i < 60; i++) begin
            cycle('1, '0, '0);
            if (serdes_v_o[3] === 1'b1 && first3 < 0) first3 = i + 1;
            for (int l = 0; l < LN; l++) begin
                n_vec++;
                if (serdes_v_o[l] !== exp_v[l] || serdes_head_o[l*HEAD_W +: HEAD_W] !== exp_h[l] ||
                    serdes_data_o[l*DATA_W +: DATA_W] !== exp_d[l]) begin
                    n_bad++;
                    $display("FAIL skew cyc %0d lane %0d: got v=%b h=%b d=%h want v=%b h=%b d=%h",
                             i, l, serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                             serdes_data_o[l*DATA_W +: DATA_W], exp_v[l], exp_h[l], exp_d[l]);
                end
            end
        end
        n_vec++;
        if (first3 != 16) begin
            n_bad++;
            $display("FAIL skew_clamp: lane 3 first valid after %0d writes, want 16", first3);
        end
    endtask

    task automatic test_slip();
        logic [LN-1:0] sl;
        do_reset('0, {7'd70, 7'd0, 7'd65, 7'd5});
        for (int i = 0; i < 80; i++) begin
            sl = LN'($urandom) & LN'($urandom);
            sl[0] = (i < 61);
            cycle('1, sl, '0);
            for (int l = 0; l < LN; l++) begin
                n_vec++;
                if (serdes_v_o[l] !== exp_v[l] || serdes_head_o[l*HEAD_W +: HEAD_W] !== exp_h[l] ||
                    serdes_data_o[l*DATA_W +: DATA_W] !== exp_d[l] ||
                    off_o[l*OW +: OW] !== OW'(off_m[l])) begin
                    n_bad++;
                    $display("FAIL slip cyc %0d lane %0d: got v=%b h=%b d=%h off=%0d want v=%b h=%b d=%h off=%0d",
                             i, l, serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                             serdes_data_o[l*DATA_W +: DATA_W], off_o[l*OW +: OW],
                             exp_v[l], exp_h[l], exp_d[l], off_m[l]);
                end
            end
        end
        n_vec++;
        if (off_o[OW-1:0] !== 7'd0) begin
            n_bad++;
            $display("FAIL slip_wrap: lane 0 off=%0d after 61 slips from 5, want 0", off_o[OW-1:0]);
        end
    endtask

    task automatic test_toggle();
        do_reset({4'd2, 4'd2, 4'd2, 4'd2}, {7'd65, 7'd33, 7'd1, 7'd0});
        for (int i = 0; i < 40; i++) begin
            cycle((i % 2 == 0) ? '1 : '0, '0, '0);
            for (int l = 0; l < LN; l++) begin
                n_vec++;
                if (serdes_v_o[l] !== exp_v[l] || serdes_head_o[l*HEAD_W +: HEAD_W] !== exp_h[l] ||
                    serdes_data_o[l*DATA_W +: DATA_W] !== exp_d[l]) begin
                    n_bad++;
                    $display("FAIL toggle cyc %0d lane %0d: got v=%b h=%b d=%h want v=%b h=%b d=%h",
                             i, l, serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                             serdes_data_o[l*DATA_W +: DATA_W], exp_v[l], exp_h[l], exp_d[l]);
                end
            end
        end
    endtask

    task automatic test_midreset();
        logic [LN*SW-1:0] sk;
        sk = (LN*SW)'($urandom);
        do_reset(sk, '0);
        for (int i = 0; i < 130; i++) begin
            if (i == 100) begin
                do_reset(sk, '0);
                for (int l = 0; l < LN; l++) begin
                    n_vec++;
                    if (serdes_v_o[l] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL midreset_flush lane %0d: got v=%b want 0", l, serdes_v_o[l]);
                    end
                end
            end
            cycle('1, '0, '0);
            for (int l = 0; l < LN; l++) begin
                n_vec++;
                if (serdes_v_o[l] !== exp_v[l] || serdes_head_o[l*HEAD_W +: HEAD_W] !== exp_h[l] ||
                    serdes_data_o[l*DATA_W +: DATA_W] !== exp_d[l]) begin
                    n_bad++;
                    $display("FAIL midreset cyc %0d lane %0d: got v=%b h=%b d=%h want v=%b h=%b d=%h",
                             i, l, serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                             serdes_data_o[l*DATA_W +: DATA_W], exp_v[l], exp_h[l], exp_d[l]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [LN*OW-1:0] of;
        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < LN; l++) of[l*OW +: OW] = OW'($urandom_range(0, 127));
            do_reset((LN*SW)'($urandom), of);
            for (int i = 0; i < 150; i++) begin
                cycle(LN'($urandom) | LN'($urandom),
                      LN'($urandom) & LN'($urandom) & LN'($urandom), '0);
                for (int l = 0; l < LN; l++) begin
                    n_vec++;
                    if (serdes_v_o[l] !== exp_v[l] || serdes_head_o[l*HEAD_W +: HEAD_W] !== exp_h[l] ||
                        serdes_data_o[l*DATA_W +: DATA_W] !== exp_d[l] ||
                        off_o[l*OW +: OW] !== OW'(off_m[l])) begin
                        n_bad++;
                        $display("FAIL random r%0d cyc %0d lane %0d: got v=%b h=%b d=%h off=%0d want v=%b h=%b d=%h off=%0d",
                                 r, i, l, serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                                 serdes_data_o[l*DATA_W +: DATA_W], off_o[l*OW +: OW],
                                 exp_v[l], exp_h[l], exp_d[l], off_m[l]);
                    end
                end
            end
        end
    endtask

`ifdef PCS_LB_ERR_INJ_EN
    task automatic test_err_inj();
        int bad_hdr [LN];
        for (int l = 0; l < LN; l++) bad_hdr[l] = 0;
        do_reset('0, '0);
        for (int i = 0; i < 30; i++) begin
            if (i == 8 || i == 9) cycle('0, '0, 4'b0100);
            else cycle('1, '0, '0);
            for (int l = 0; l < LN; l++) begin
                if (serdes_v_o[l] === 1'b1 && serdes_head_o[l*HEAD_W +: HEAD_W] === 2'b00)
                    bad_hdr[l]++;
                n_vec++;
                if (serdes_v_o[l] !== exp_v[l] || serdes_head_o[l*HEAD_W +: HEAD_W] !== exp_h[l] ||
                    serdes_data_o[l*DATA_W +: DATA_W] !== exp_d[l]) begin
                    n_bad++;
                    $display("FAIL err_inj cyc %0d lane %0d: got v=%b h=%b d=%h want v=%b h=%b d=%h",
                             i, l, serdes_v_o[l], serdes_head_o[l*HEAD_W +: HEAD_W],
                             serdes_data_o[l*DATA_W +: DATA_W], exp_v[l], exp_h[l], exp_d[l]);
                end
            end
        end
        for (int l = 0; l < LN; l++) begin
            n_vec++;
            if (bad_hdr[l] != ((l == 2) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL err_inj_count lane %0d: got %0d bad headers want %0d",
                         l, bad_hdr[l], (l == 2) ? 1 : 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_skew();
        test_slip();
        test_toggle();
        test_midreset();
        test_random();
`ifdef PCS_LB_ERR_INJ_EN
        test_err_inj();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
